// File: rtl/rr_arbiter.sv
// Round-robin arbiter with packet lock: the owner keeps its grant while its request stays high.
// Defining ARB_TIMEOUT_EN adds a MAX_HOLD-cycle limit on a single grant.
module rr_arbiter #(
  parameter int unsigned N         = 5,
  parameter int unsigned MAX_HOLD  = 8,
  localparam int unsigned IdxW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IdxW-1:0] gnt_idx
);

  if (N < 2 || N > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
    $error("rr_arbiter: parameter out of legal range");
  end

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;

  logic            owner_req;
  logic [N-1:0]    cand_req;
  logic [N-1:0]    rot;
  logic [IdxW:0]   sum;
  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic            take;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD);
  logic [HoldW-1:0] hold_q, hold_d;
  logic             hold_expired;
  assign hold_expired = (hold_q == HoldW'(MAX_HOLD - 1));
`endif

  // Masking the current owner is a no-op in idle (gnt_q is zero) and on release (its req is low).
  assign owner_req = |(req & gnt_q);
  assign cand_req  = req & ~gnt_q;

  always_comb begin
    rot       = N'({cand_req, cand_req} >> ptr_q);
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int j = 0; j < N; j++) begin
      if (!win_found && rot[j]) begin
        win_found = 1'b1;
        sum       = {1'b0, ptr_q} + (IdxW+1)'(j);
        win_idx   = (sum >= (IdxW+1)'(N)) ? IdxW'(sum - (IdxW+1)'(N)) : IdxW'(sum);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      StIdle: take = win_found;
      StBusy: begin
        if (!owner_req) begin
          take = win_found;
          if (!win_found) begin
            state_d = StIdle;
            gnt_d   = '0;
            valid_d = 1'b0;
            idx_d   = '0;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_expired) begin
          // Hand over if anyone else is waiting, otherwise the owner starts a fresh hold window.
          take = win_found;
          if (!win_found) hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
    endcase

    if (take) begin
      state_d = StBusy;
      gnt_d   = N'(1) << win_idx;
      valid_d = 1'b1;
      idx_d   = win_idx;
      ptr_d   = (win_idx == IdxW'(N - 1)) ? '0 : win_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule
